// File: rtl/fir_mac.sv
// fir_mac: pipelined signed multiply-accumulate for the receiver FIR datapath.
// Each valid beat carries a sample/coefficient pair plus frame markers. The
// signed product is formed with a sign-magnitude multiplier, accumulated over
// the frame, then rounded (half-up), shifted and saturated to OUT_WIDTH.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_valid    qualifies i_a / i_b / i_first / i_last this cycle
//   i_a        signed sample (A_WIDTH)
//   i_b        signed coefficient (B_WIDTH)
//   i_first    beat starts a new frame
//   i_last     beat ends the frame
//   o_y        rounded, saturated frame result (OUT_WIDTH), held between pulses
//   o_y_valid  one-cycle pulse marking a new o_y / o_y_sat
//   o_y_sat    o_y was clipped for this result
//
// Latency: Last sampled on edge n gives o_y_valid high after edge n+5.
module fir_mac #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 40,
    parameter int SHIFT     = 16,
    parameter int OUT_WIDTH = 18
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic signed [A_WIDTH-1:0]   i_a,
    input  logic signed [B_WIDTH-1:0]   i_b,
    input  logic                        i_first,
    input  logic                        i_last,
    output logic signed [OUT_WIDTH-1:0] o_y,
    output logic                        o_y_valid,
    output logic                        o_y_sat
);

    localparam int PW = A_WIDTH + B_WIDTH;

    // Rounding constant 2^(SHIFT-1); zero when no shift is applied.
    localparam logic signed [ACC_WIDTH:0] ONE  = 1;
    localparam logic signed [ACC_WIDTH:0] RND  =
        (SHIFT > 0) ? (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_WIDTH:0] YMAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] YMIN =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // Flag shift registers, bit k-1 holds stage Sk (S1..S4).
    logic [3:0] r_vld_pipe;
    logic [3:0] r_first_pipe;
    logic [3:0] r_last_pipe;
    logic       r_vld5;
    logic       r_last5;

    // Datapath registers (not reset; qualified by the flag pipeline).
    logic signed [A_WIDTH-1:0]   r_a;
    logic signed [B_WIDTH-1:0]   r_b;
    logic        [A_WIDTH-1:0]   r_mag_a;
    logic        [B_WIDTH-1:0]   r_mag_b;
    logic                        r_sgn2;
    logic        [PW-1:0]        r_prod_u;
    logic                        r_sgn3;
    logic        [PW-1:0]        r_prod;
    logic signed [ACC_WIDTH-1:0] r_acc;

    logic signed [ACC_WIDTH-1:0] w_p_ext;
    logic signed [ACC_WIDTH:0]   w_rnd;
    logic signed [ACC_WIDTH:0]   w_shr;

    // Flags: reset clears everything in flight, and a beat coincident with
    // reset never enters the pipe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe   <= '0;
            r_first_pipe <= '0;
            r_last_pipe  <= '0;
            r_vld5       <= 1'b0;
            r_last5      <= 1'b0;
        end else begin
            r_vld_pipe   <= {r_vld_pipe[2:0],   i_valid};
            r_first_pipe <= {r_first_pipe[2:0], i_first};
            r_last_pipe  <= {r_last_pipe[2:0],  i_last};
            r_vld5       <= r_vld_pipe[3];
            r_last5      <= r_last_pipe[3];
        end
    end

    // S1..S4: sign-magnitude multiply. Negating the most-negative input wraps
    // to 2^(W-1), which read as unsigned is the correct magnitude.
    always_ff @(posedge i_clk) begin
        r_a      <= i_a;
        r_b      <= i_b;
        r_mag_a  <= r_a[A_WIDTH-1] ? -r_a : r_a;
        r_mag_b  <= r_b[B_WIDTH-1] ? -r_b : r_b;
        r_sgn2   <= r_a[A_WIDTH-1] ^ r_b[B_WIDTH-1];
        r_prod_u <= PW'(r_mag_a) * PW'(r_mag_b);
        r_sgn3   <= r_sgn2;
        r_prod   <= r_sgn3 ? -r_prod_u : r_prod_u;
    end

    assign w_p_ext = {{(ACC_WIDTH - PW){r_prod[PW-1]}}, r_prod};

    // S5: accumulator; bubbles hold, First restarts, overflow wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (r_vld_pipe[3]) begin
            r_acc <= r_first_pipe[3] ? w_p_ext : r_acc + w_p_ext;
        end
    end

    // S6: round half-up at ACC_WIDTH+1 bits so the rounding add cannot wrap.
    assign w_rnd = {r_acc[ACC_WIDTH-1], r_acc} + RND;
    assign w_shr = w_rnd >>> SHIFT;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_y       <= '0;
            o_y_valid <= 1'b0;
            o_y_sat   <= 1'b0;
        end else begin
            o_y_valid <= 1'b0;
            if (r_vld5 && r_last5) begin
                o_y_valid <= 1'b1;
                if (w_shr > YMAX) begin
                    o_y     <= YMAX[OUT_WIDTH-1:0];
                    o_y_sat <= 1'b1;
                end else if (w_shr < YMIN) begin
                    o_y     <= YMIN[OUT_WIDTH-1:0];
                    o_y_sat <= 1'b1;
                end else begin
                    o_y     <= w_shr[OUT_WIDTH-1:0];
                    o_y_sat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_mac.sv
// Directed testbench for fir_mac with hand-computed expected results.
module tb_fir_mac;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_valid;
    logic signed [15:0] i_a;
    logic signed [17:0] i_b;
    logic               i_first;
    logic               i_last;
    logic signed [17:0] o_y;
    logic               o_y_valid;
    logic               o_y_sat;

    fir_mac dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_first   (i_first),
        .i_last    (i_last),
        .o_y       (o_y),
        .o_y_valid (o_y_valid),
        .o_y_sat   (o_y_sat)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_edge;

    int q_y[$];
    bit q_sat[$];
    int q_cyc[$];

    always @(posedge i_clk) cyc++;

    // Record every result pulse with the edge count at which it appeared.
    always @(negedge i_clk) begin
        if (o_y_valid === 1'b1) begin
            q_y.push_back(int'(o_y));
            q_sat.push_back(o_y_sat);
            q_cyc.push_back(cyc);
        end
    end

    task automatic clear_q();
        q_y.delete();
        q_sat.delete();
        q_cyc.delete();
    endtask

    task automatic drive_beat(input int a, input int b, input bit f, input bit l);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_a     = 16'(a);
        i_b     = 18'(b);
        i_first = f;
        i_last  = l;
        if (l) last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_first = 1'b0;
            i_last  = 1'b0;
            i_a     = 16'($urandom);
            i_b     = 18'($urandom);
        end
    endtask

    task automatic test_reset();
        clear_q();
        repeat (2) begin
            @(negedge i_clk);
            n_chk++;
            if (o_y !== 18'sd0 || o_y_valid !== 1'b0 || o_y_sat !== 1'b0)
                $display("FAIL reset_hold: y=%0d vld=%b sat=%b, want 0/0/0", o_y, o_y_valid, o_y_sat);
            else n_pass++;
            i_valid = 1'b1;
            i_a     = 16'($urandom);
            i_b     = 18'($urandom);
            i_first = 1'($urandom);
            i_last  = 1'b1;
        end
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_first = 1'b0;
        repeat (6) begin
            @(negedge i_clk);
            n_chk++;
            if (o_y !== 18'sd0 || o_y_valid !== 1'b0 || o_y_sat !== 1'b0)
                $display("FAIL reset_release: y=%0d vld=%b sat=%b, want 0/0/0", o_y, o_y_valid, o_y_sat);
            else n_pass++;
        end
        n_chk++;
        if (q_y.size() != 0) $display("FAIL reset_pulses: got %0d pulses, want 0", q_y.size());
        else n_pass++;
    endtask

    task automatic test_single_extreme();
        int e;
        clear_q();
        drive_beat(-32768, -131072, 1, 1);
        e = last_edge;
        idle(8);
        n_chk++;
        if (q_y.size() != 1) $display("FAIL extreme_count: got %0d pulses, want 1", q_y.size());
        else begin
            n_pass++;
            n_chk++;
            if (q_y[0] != 65536 || q_sat[0] != 1'b0)
                $display("FAIL extreme_value: y=%0d sat=%b, want 65536/0", q_y[0], q_sat[0]);
            else n_pass++;
            n_chk++;
            if (q_cyc[0] != e + 5) $display("FAIL extreme_latency: edge %0d, want %0d", q_cyc[0], e + 5);
            else n_pass++;
        end
        n_chk++;
        if (o_y !== 18'sd65536) $display("FAIL extreme_hold: y=%0d, want 65536", o_y);
        else n_pass++;
    endtask

    task automatic test_rounding();
        clear_q();
        for (int k = 0; k < 4; k++) drive_beat(1000, -2000, k == 0, k == 3);
        idle(8);
        n_chk++;
        if (q_y.size() != 1 || q_y[0] != -122 || q_sat[0] != 1'b0)
            $display("FAIL round_multitap: n=%0d y=%0d, want 1 pulse y=-122 sat=0",
                     q_y.size(), (q_y.size() > 0) ? q_y[0] : 0);
        else n_pass++;
        clear_q();
        drive_beat(1, 32768, 1, 1);
        idle(8);
        n_chk++;
        if (q_y.size() != 1 || q_y[0] != 1 || q_sat[0] != 1'b0)
            $display("FAIL round_half_up: n=%0d y=%0d, want 1 pulse y=1 sat=0",
                     q_y.size(), (q_y.size() > 0) ? q_y[0] : 0);
        else n_pass++;
    endtask

    task automatic test_saturation();
        clear_q();
        for (int k = 0; k < 8; k++) drive_beat(32767, 131071, k == 0, k == 7);
        idle(8);
        n_chk++;
        if (q_y.size() != 1 || q_y[0] != 131071 || q_sat[0] != 1'b1)
            $display("FAIL sat_pos: n=%0d y=%0d sat=%b, want 131071/1",
                     q_y.size(), (q_y.size() > 0) ? q_y[0] : 0, (q_sat.size() > 0) ? q_sat[0] : 1'b0);
        else n_pass++;
        clear_q();
        for (int k = 0; k < 8; k++) drive_beat(32767, -131071, k == 0, k == 7);
        idle(8);
        n_chk++;
        if (q_y.size() != 1 || q_y[0] != -131072 || q_sat[0] != 1'b1)
            $display("FAIL sat_neg: n=%0d y=%0d sat=%b, want -131072/1",
                     q_y.size(), (q_y.size() > 0) ? q_y[0] : 0, (q_sat.size() > 0) ? q_sat[0] : 1'b0);
        else n_pass++;
        // Y_Sat must clear on the next unclipped result.
        clear_q();
        drive_beat(1, 32768, 1, 1);
        idle(8);
        n_chk++;
        if (q_y.size() != 1 || q_y[0] != 1 || q_sat[0] != 1'b0)
            $display("FAIL sat_clear: n=%0d sat=%b, want 1 pulse sat=0",
                     q_y.size(), (q_sat.size() > 0) ? q_sat[0] : 1'b1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e1;
        int e2;
        clear_q();
        drive_beat(100, 65536, 1, 0);
        idle(3);
        drive_beat(100, 65536, 0, 1);
        e1 = last_edge;
        drive_beat(1, 32768, 1, 1);
        e2 = last_edge;
        idle(10);
        n_chk++;
        if (q_y.size() != 2) $display("FAIL b2b_count: got %0d pulses, want 2", q_y.size());
        else begin
            n_pass++;
            n_chk++;
            if (q_y[0] != 200 || q_y[1] != 1)
                $display("FAIL b2b_values: y0=%0d y1=%0d, want 200 and 1", q_y[0], q_y[1]);
            else n_pass++;
            n_chk++;
            if (q_cyc[0] != e1 + 5 || q_cyc[1] != e2 + 5 || q_cyc[1] - q_cyc[0] != 1)
                $display("FAIL b2b_timing: edges %0d,%0d want %0d,%0d", q_cyc[0], q_cyc[1], e1 + 5, e1 + 6);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int e;
        clear_q();
        drive_beat(500, 1000, 1, 0);
        drive_beat(500, 1000, 0, 0);
        drive_beat(500, 1000, 0, 1);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_first = 1'b1;
        i_last  = 1'b1;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        idle(10);
        n_chk++;
        if (q_y.size() != 0) $display("FAIL midreset_drop: got %0d pulses, want 0", q_y.size());
        else n_pass++;
        // 2 * 10 * 6554 = 131080; +32768 >> 16 = 2
        drive_beat(10, 6554, 1, 0);
        drive_beat(10, 6554, 0, 1);
        e = last_edge;
        idle(8);
        n_chk++;
        if (q_y.size() != 1 || q_y[0] != 2 || q_sat[0] != 1'b0 || q_cyc[0] != e + 5)
            $display("FAIL midreset_frame: n=%0d y=%0d, want 1 pulse y=2 at edge %0d",
                     q_y.size(), (q_y.size() > 0) ? q_y[0] : 0, e + 5);
        else n_pass++;
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_first = 1'b0;
        i_last  = 1'b0;
        test_reset();
        test_single_extreme();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_mac.md
# fir_mac

Parametrised pipelined signed multiply-accumulate for the receiver FIR datapath. Streams sample/coefficient pairs tagged with frame markers, forms each signed product with a sign-magnitude multiplier pipeline, and accumulates one output per frame. Each result is rounded, scaled and saturated to the output width. It sits between the tap/coefficient sequencer and the decimated output stream.

## Interface
- A_WIDTH, 16: signed sample width.
- B_WIDTH, 18: signed coefficient width.
- ACC_WIDTH, 40: accumulator width. Must be ≥ A_WIDTH+B_WIDTH plus the log2 of the maximum frame length.
- SHIFT, 16: arithmetic right shift applied to the accumulator at output. Range 0 ≤ SHIFT < ACC_WIDTH.
- OUT_WIDTH, 18: signed output width. Must be ≤ ACC_WIDTH−SHIFT.
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Valid  in  1  A/B/First/Last qualify this cycle.
- A  in  A_WIDTH  signed sample.
- B  in  B_WIDTH  signed coefficient.
- First  in  1  beat starts a new frame.
- Last  in  1  beat ends the frame.
- Y  out  OUT_WIDTH  rounded, saturated frame result.
- Y_Valid  out  1  one-cycle pulse; Y and Y_Sat are valid.
- Y_Sat  out  1  Y was clipped this result.

## Operation
- Pipeline stages; each stage carries the Valid/First/Last flags forward:
  - S1: register A, B and the flags.
  - S2: magnitudes |A| and |B| as unsigned A_WIDTH/B_WIDTH values (most-negative input gives 2^(W−1), which is correct). Sign = A msb XOR B msb.
  - S3: unsigned product |A|·|B|, A_WIDTH+B_WIDTH bits.
  - S4: signed product P, the two's complement of S3 when the sign is set.
- S5, accumulator (updates only on a valid beat; holds on bubbles):
  - If First: Acc ← sext(P).
  - Otherwise: Acc ← Acc + sext(P), wrapping modulo 2^ACC_WIDTH. Wrap is not detected.
- S6, output (only on a valid beat whose Last is set):
  - R = (Acc + 2^(SHIFT−1)) >>> SHIFT, computed at ACC_WIDTH+1 bits. Rounding is round-half-up. No rounding term when SHIFT=0.
  - Saturate R to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] and set Y_Sat if clipped.
  - Pulse Y_Valid.
- First and Last on the same beat: single-beat frame, Y = round(P).
- Beats without Valid are ignored entirely, including their First/Last.
- Back-to-back frames (Last then First on the next valid beat) need no gap.
- Beats after reset that arrive before any First accumulate onto Acc=0.
- Y and Y_Sat hold their last values between Y_Valid pulses.

## Timing
- Full throughput: one beat per clock, no backpressure.
- Latency: a Last beat sampled on edge n produces Y_Valid high after edge n+5, i.e. 6 clocks inclusive of the sampling edge. The product is available after the 4-clock multiply, plus accumulate and output stages.
- Reset value: Y=0, Y_Valid=0, Y_Sat=0, Acc=0, and all pipeline flag registers are 0. Data registers need not reset.
- Reset mid-frame: every in-flight beat is discarded and no Y_Valid is produced for it. The first Valid beat sampled on the edge after Reset deasserts is processed normally.
- Reset and Valid in the same cycle: Reset wins and the beat is dropped.

## Test plan
- Reset: assert Reset 2 cycles with random inputs and Valid=1 → Y=0, Y_Valid=0, Y_Sat=0 throughout and for 6 cycles after release with Valid=0.
- Single-beat extremes: Valid, First and Last with A=−32768, B=−131072 → exactly 6 clocks later Y=65536, Y_Sat=0, one-cycle Y_Valid.
- Multi-tap rounding: 4 beats of A=1000, B=−2000 (First on beat 1, Last on beat 4) → Acc=−8,000,000 and Y=−122. Repeat with A=1, B=32768, single beat → Y=1 (half rounds up).
- Saturation: 8 beats of A=32767, B=131071 → Y=131071, Y_Sat=1. Same beats with B=−131071 → Y=−131072, Y_Sat=1.
- Bubbles and back-to-back frames: frame 1 is (100, 65536) twice with 3 idle cycles between beats; frame 2 is (1, 32768) single-beat on the cycle after frame 1's Last → Y=200 then Y=1, Y_Valid pulses one and N+1 cycles apart, exactly 2 pulses.
- Reset mid-frame: 3 beats in flight, Reset for 1 cycle → no Y_Valid. A following 2-beat frame (10, 6553.6→6554) gives a result matching the reference model.
